// File: rtl/flipchip_gate_bank.sv
// Bank of CHANNELS clocked gates replacing the fixed 4-input NAND FlipChip cards:
// selectable gate function, modelled propagation delay, pulse-rejection filter and fault forcing.
module flipchip_gate_bank #(
    parameter int CHANNELS = 6,
    parameter int INPUTS   = 4,
    parameter int MODE     = 0,
    parameter int DELAY    = 2,
    parameter int FILTER   = 3,
    parameter int HI_OUTS  = 2,
    // A zero-width port is not legal, so HI_OUTS=0 still exposes one tie-high bit.
    localparam int HI_W    = (HI_OUTS > 0) ? HI_OUTS : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS*INPUTS-1:0] in,
    input  logic [CHANNELS-1:0]        force_en,
    input  logic [CHANNELS-1:0]        force_val,
    output logic [CHANNELS-1:0]        out,
    output logic [CHANNELS-1:0]        changed,
    output logic [HI_W-1:0]            hi
);

    localparam int                  F_EFF    = (FILTER < 1) ? 1 : FILTER;
    localparam logic [3:0]          CNT_LAST = 4'(F_EFF - 1);
    localparam logic                RST_BIT  = (MODE == 0) || (MODE == 2);
    localparam logic [CHANNELS-1:0] RST_VEC  = {CHANNELS{RST_BIT}};

    if (MODE < 0 || MODE > 3) begin : g_bad_mode
        $error("flipchip_gate_bank: MODE must be 0 (NAND), 1 (AND), 2 (NOR) or 3 (OR)");
    end
    if (CHANNELS < 1 || CHANNELS > 32 || INPUTS < 1 || INPUTS > 8) begin : g_bad_shape
        $error("flipchip_gate_bank: CHANNELS must be 1..32 and INPUTS 1..8");
    end
    if (DELAY < 0 || DELAY > 15 || FILTER < 0 || FILTER > 15 || HI_OUTS < 0 || HI_OUTS > 4) begin : g_bad_timing
        $error("flipchip_gate_bank: DELAY/FILTER must be 0..15 and HI_OUTS 0..4");
    end

    function automatic logic gate_fn(input logic [INPUTS-1:0] x);
        case (MODE)
            0:       gate_fn = ~&x;
            1:       gate_fn = &x;
            2:       gate_fn = ~|x;
            default: gate_fn = |x;
        endcase
    endfunction

    logic [CHANNELS-1:0] r;
    logic [CHANNELS-1:0] d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            r[c] = gate_fn(in[c*INPUTS +: INPUTS]);
        end
    end

    if (DELAY == 0) begin : g_no_delay
        assign d = r;
    end else begin : g_delay
        logic [CHANNELS-1:0] stage [DELAY];

        // NOTE: the delay line is a handful of flops, not a RAM, so resetting every stage is cheap
        // and is what guarantees no pending transition survives reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DELAY; i++) begin
                    stage[i] <= RST_VEC;
                end
            end else begin
                stage[0] <= r;
                for (int i = 1; i < DELAY; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign d = stage[DELAY-1];
    end

    logic [3:0]          cnt     [CHANNELS];
    logic [3:0]          cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] out_nxt;

    // Forcing overrides the filter and restarts its persistence count from zero.
    always_comb begin
        out_nxt = out;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_nxt[c] = '0;
            if (force_en[c]) begin
                out_nxt[c] = force_val[c];
            end else if (d[c] != out[c]) begin
                if (cnt[c] == CNT_LAST) begin
                    out_nxt[c] = d[c];
                end else begin
                    cnt_nxt[c] = cnt[c] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            out     <= RST_VEC;
            changed <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            out     <= out_nxt;
            changed <= out_nxt ^ out;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt[c] <= cnt_nxt[c];
            end
        end
    end

    assign hi = '1;

endmodule
